// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   GRP_W   : width of one lookahead group (4 bits)
//   MAX_W   : largest supported operand width (64)
//   s1_t    : stage-1 register contents, sized for MAX_W; narrower adders
//             zero-extend into it and read back only their low bits
//   grp_pg  : group propagate/generate from 4-bit p/g, returned as {P, G}
package cla_pkg;

  localparam int unsigned GRP_W   = 4;
  localparam int unsigned MAX_W   = 64;
  localparam int unsigned MAX_GRP = MAX_W / GRP_W;

  typedef struct packed {
    logic [MAX_W-1:0]   p;
    logic [MAX_W-1:0]   g;
    logic [MAX_GRP-1:0] grp_p;
    logic [MAX_GRP-1:0] grp_g;
    logic               cin;
  } s1_t;

  function automatic logic [1:0] grp_pg(input logic [GRP_W-1:0] p,
                                        input logic [GRP_W-1:0] g);
    logic gp;
    logic gg;
    gp = &p;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gp, gg};
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group.
//   p, g   : per-bit propagate / generate
//   ci     : group carry-in
//   c      : carry into each bit of the group (c[0] = ci)
//   grp_p  : group propagate
//   grp_g  : group generate
module cla_group4
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] p,
  input  logic [GRP_W-1:0] g,
  input  logic             ci,
  output logic [GRP_W-1:0] c,
  output logic             grp_p,
  output logic             grp_g
);

  always_comb begin
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    {grp_p, grp_g} = grp_pg(p, g);
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake.
//   Stage 1 registers per-bit p/g, group P/G and cin; stage 2 resolves the
//   group carries with a second lookahead level and registers sum/cout.
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready has no path from in_valid)
//   a, b, cin            : operands and carry-in
//   out_valid / out_ready: result handshake
//   sum, cout            : a+b+cin mod 2^WIDTH, carry out of the MSB
//   ovf                  : two's-complement overflow (only with CLA_OVF_FLAG_EN)
// Parameter WIDTH: multiple of 4 in [4, 64].
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NGRP = WIDTH / GRP_W;

  if (WIDTH < GRP_W || WIDTH > MAX_W || (WIDTH % GRP_W) != 0) begin : g_bad_width
    $fatal(1, "cla_adder_pipe: WIDTH must be a multiple of 4 between 4 and 64");
  end

  // Handshake
  logic s1_valid;
  logic s2_valid;
  logic adv1;
  logic adv2;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  // Stage 1 combinational
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic [NGRP-1:0]  gp_in;
  logic [NGRP-1:0]  gg_in;

  assign p_in = a ^ b;
  assign g_in = a & b;

  always_comb begin
    gp_in = '0;
    gg_in = '0;
    for (int unsigned k = 0; k < NGRP; k++) begin
      {gp_in[k], gg_in[k]} = grp_pg(p_in[k*GRP_W +: GRP_W], g_in[k*GRP_W +: GRP_W]);
    end
  end

  s1_t s1_q;

  // Stage 2 combinational
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g_s;
  logic [NGRP-1:0]  gp_s;
  logic [NGRP-1:0]  gg_s;
  logic [NGRP:0]    grp_c;
  logic [WIDTH-1:0] bit_c;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [NGRP-1:0]  unused_gp;
  logic [NGRP-1:0]  unused_gg;
  logic             unused_s1;

  assign p_s       = s1_q.p[WIDTH-1:0];
  assign g_s       = s1_q.g[WIDTH-1:0];
  assign gp_s      = s1_q.grp_p[NGRP-1:0];
  assign gg_s      = s1_q.grp_g[NGRP-1:0];
  assign unused_s1 = ^s1_q;

  // Each group carry is expanded as an explicit sum of products
  // (G[j] & P[j+1..k-1], plus cin & P[0..k-1]) so no group waits on its
  // neighbour's carry.
  always_comb begin
    logic term;
    logic carry;
    term  = 1'b0;
    carry = 1'b0;
    grp_c = '0;
    for (int unsigned k = 0; k <= NGRP; k++) begin
      term = s1_q.cin;
      for (int unsigned j = 0; j < k; j++) begin
        term = term & gp_s[j];
      end
      carry = term;
      for (int unsigned j = 0; j < k; j++) begin
        term = gg_s[j];
        for (int unsigned m = j + 1; m < k; m++) begin
          term = term & gp_s[m];
        end
        carry = carry | term;
      end
      grp_c[k] = carry;
    end
  end

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    cla_group4 u_grp (
      .p     (p_s[k*GRP_W +: GRP_W]),
      .g     (g_s[k*GRP_W +: GRP_W]),
      .ci    (grp_c[k]),
      .c     (bit_c[k*GRP_W +: GRP_W]),
      .grp_p (unused_gp[k]),
      .grp_g (unused_gg[k])
    );
  end

  assign sum_d  = p_s ^ bit_c;
  assign cout_d = grp_c[NGRP];

`ifdef CLA_OVF_FLAG_EN
  logic ovf_d;
  assign ovf_d = grp_c[NGRP] ^ bit_c[WIDTH-1];
`endif

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      sum      <= '0;
      cout     <= 1'b0;
`ifdef CLA_OVF_FLAG_EN
      ovf      <= 1'b0;
`endif
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_q <= '{p: MAX_W'(p_in), g: MAX_W'(g_in),
                    grp_p: MAX_GRP'(gp_in), grp_g: MAX_GRP'(gg_in), cin: cin};
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          sum  <= sum_d;
          cout <= cout_d;
`ifdef CLA_OVF_FLAG_EN
          ovf  <= ovf_d;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: WIDTH=32 main instance plus
// WIDTH=4 (exhaustive) and WIDTH=64 (random) instances on the same clock/reset.
// CLA_OVF_FLAG_EN enables the ovf checks.
module tb_cla_adder_pipe;

  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // WIDTH=32
  logic         in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b0, cout;
  logic [W-1:0] a = '0, b = '0, sum;
  // WIDTH=4
  logic         in_valid_4 = 1'b0, in_ready_4, cin_4 = 1'b0, out_valid_4, out_ready_4 = 1'b0, cout_4;
  logic [3:0]   a_4 = '0, b_4 = '0, sum_4;
  // WIDTH=64
  logic         in_valid_64 = 1'b0, in_ready_64, cin_64 = 1'b0, out_valid_64, out_ready_64 = 1'b0, cout_64;
  logic [63:0]  a_64 = '0, b_64 = '0, sum_64;
`ifdef CLA_OVF_FLAG_EN
  logic ovf, ovf_4, ovf_64;
`endif

  cla_adder_pipe #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef CLA_OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );

  cla_adder_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_4), .in_ready(in_ready_4),
    .a(a_4), .b(b_4), .cin(cin_4), .out_valid(out_valid_4), .out_ready(out_ready_4),
    .sum(sum_4), .cout(cout_4)
`ifdef CLA_OVF_FLAG_EN
    , .ovf(ovf_4)
`endif
  );

  cla_adder_pipe #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_64), .in_ready(in_ready_64),
    .a(a_64), .b(b_64), .cin(cin_64), .out_valid(out_valid_64), .out_ready(out_ready_64),
    .sum(sum_64), .cout(cout_64)
`ifdef CLA_OVF_FLAG_EN
    , .ovf(ovf_64)
`endif
  );

  // Reference: plain wide addition. Returns {ovf, cout, sum[63:0]}.
  function automatic logic [65:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input int unsigned w);
    logic [63:0] mask;
    logic [64:0] full;
    logic        ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    full = {1'b0, x & mask} + {1'b0, y & mask} + {64'd0, ci};
    ov   = (x[w-1] == y[w-1]) && (full[w-1] != x[w-1]);
    return {ov, full[w], full[63:0] & mask};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out got valid=%b sum=%h cout=%b exp 0/0/0", out_valid, sum, cout);
    end
    n_tests++;
    if (out_valid_4 !== 1'b0 || out_valid_64 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_widths got v4=%b v64=%b exp 0/0", out_valid_4, out_valid_64);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early got out_valid=%b exp 0", out_valid);
    end
    @(negedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b1 || sum !== 32'h0 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL single_result got v=%b sum=%h cout=%b exp 1/00000000/1", out_valid, sum, cout);
    end
    @(negedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse got out_valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_carry();
    @(negedge clk);
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    a = 32'h7FFF_FFFF; b = 32'h1; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || sum !== 32'h0 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_full got v=%b sum=%h cout=%b exp 1/00000000/1", out_valid, sum, cout);
    end
    @(negedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b1 || sum !== 32'h8000_0000 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_msb got v=%b sum=%h cout=%b exp 1/80000000/0", out_valid, sum, cout);
    end
`ifdef CLA_OVF_FLAG_EN
    n_tests++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_ovf got %b exp 1", ovf);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [65:0] q[$];
    logic [65:0] e;
    int unsigned sent = 0, rcvd = 0, cyc = 0;
    while (rcvd < 100 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      in_valid = (sent < 100);
      a = $urandom; b = $urandom; cin = 1'($urandom); out_ready = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_in_ready got %b exp 1 (cycle %0d)", in_ready, cyc);
      end
      if (out_valid && out_ready) begin
        e = q.pop_front();
        rcvd++;
        n_tests++;
        if (sum !== e[W-1:0] || cout !== e[64]) begin
          n_fail++;
          $display("FAIL b2b_data #%0d got sum=%h cout=%b exp sum=%h cout=%b", rcvd, sum, cout, e[W-1:0], e[64]);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_add(64'(a), 64'(b), cin, W));
        sent++;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (rcvd != 100 || cyc != 102) begin
      n_fail++;
      $display("FAIL b2b_count got rcvd=%0d cycles=%0d exp 100/102", rcvd, cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [65:0] q[$];
    logic [65:0] e;
    logic [W:0]  held;
    int unsigned sent = 0, rcvd = 0, cyc = 0, first_out = 0;
    held = '0;
    while (rcvd < 3 && cyc < 40) begin
      @(negedge clk);
      in_valid = (sent < 3);
      a = $urandom; b = $urandom; cin = 1'($urandom);
      out_ready = (cyc >= 5);
      #1;
      if (cyc == 2) held = {cout, sum};
      if (cyc >= 2 && cyc <= 4) begin
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || {cout, sum} !== held) begin
          n_fail++;
          $display("FAIL bp_stall cyc %0d got in_ready=%b v=%b data=%h exp 0/1/%h", cyc, in_ready, out_valid, {cout, sum}, held);
        end
      end
      if (out_valid && out_ready) begin
        if (rcvd == 0) first_out = cyc;
        e = q.pop_front();
        rcvd++;
        n_tests++;
        if (sum !== e[W-1:0] || cout !== e[64] || cyc != first_out + rcvd - 1) begin
          n_fail++;
          $display("FAIL bp_data #%0d cyc %0d got sum=%h cout=%b exp sum=%h cout=%b", rcvd, cyc, sum, cout, e[W-1:0], e[64]);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_add(64'(a), 64'(b), cin, W));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (rcvd != 3 || first_out != 5) begin
      n_fail++;
      $display("FAIL bp_count got rcvd=%0d first=%0d exp 3/5", rcvd, first_out);
    end
  endtask

  task automatic test_random_toggle();
    logic [65:0] q[$];
    logic [65:0] e;
    logic [W:0]  held;
    logic        stalled = 1'b0;
    int unsigned sent = 0, rcvd = 0, cyc = 0, both = 0;
    held = '0;
    while (rcvd < 1000 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      in_valid = (sent < 1000) && ($urandom_range(3) != 0);
      a = $urandom; b = $urandom; cin = 1'($urandom);
      out_ready = ($urandom_range(2) != 0);
      #1;
      if (stalled) begin
        n_tests++;
        if (out_valid !== 1'b1 || {cout, sum} !== held) begin
          n_fail++;
          $display("FAIL rnd_hold got v=%b data=%h exp 1/%h", out_valid, {cout, sum}, held);
        end
      end
      stalled = out_valid && !out_ready;
      held    = {cout, sum};
      if (out_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_dup got extra result sum=%h exp none", sum);
        end else begin
          e = q.pop_front();
          rcvd++;
          if (sum !== e[W-1:0] || cout !== e[64]) begin
            n_fail++;
            $display("FAIL rnd_data #%0d got sum=%h cout=%b exp sum=%h cout=%b", rcvd, sum, cout, e[W-1:0], e[64]);
          end
`ifdef CLA_OVF_FLAG_EN
          n_tests++;
          if (ovf !== e[65]) begin
            n_fail++;
            $display("FAIL rnd_ovf #%0d got %b exp %b", rcvd, ovf, e[65]);
          end
`endif
        end
        if (in_valid && in_ready) both++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_add(64'(a), 64'(b), cin, W));
        sent++;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (rcvd != 1000 || q.size() != 0 || both == 0) begin
      n_fail++;
      $display("FAIL rnd_count got rcvd=%0d left=%0d simult=%0d exp 1000/0/>0", rcvd, q.size(), both);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    a = $urandom; b = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre got out_valid=%b exp 1", out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async got v=%b sum=%h cout=%b exp 0/0/0", out_valid, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_stale cycle %0d got out_valid=%b exp 0", i, out_valid);
      end
    end
  endtask

  task automatic test_width4_exhaustive();
    logic [65:0] q[$];
    logic [65:0] e;
    int unsigned sent = 0, rcvd = 0, cyc = 0;
    while (rcvd < 512 && cyc < 700) begin
      @(negedge clk);
      cyc++;
      in_valid_4 = (sent < 512);
      {cin_4, b_4, a_4} = 9'(sent);
      out_ready_4 = 1'b1;
      #1;
      if (out_valid_4 && out_ready_4) begin
        e = q.pop_front();
        rcvd++;
        n_tests++;
        if (sum_4 !== e[3:0] || cout_4 !== e[64]) begin
          n_fail++;
          $display("FAIL w4_data #%0d got sum=%h cout=%b exp sum=%h cout=%b", rcvd, sum_4, cout_4, e[3:0], e[64]);
        end
`ifdef CLA_OVF_FLAG_EN
        n_tests++;
        if (ovf_4 !== e[65]) begin
          n_fail++;
          $display("FAIL w4_ovf #%0d got %b exp %b", rcvd, ovf_4, e[65]);
        end
`endif
      end
      if (in_valid_4 && in_ready_4) begin
        q.push_back(ref_add(64'(a_4), 64'(b_4), cin_4, 4));
        sent++;
      end
    end
    in_valid_4 = 1'b0;
    n_tests++;
    if (rcvd != 512 || cyc != 514) begin
      n_fail++;
      $display("FAIL w4_count got rcvd=%0d cycles=%0d exp 512/514", rcvd, cyc);
    end
  endtask

  task automatic test_width64();
    logic [65:0] q[$];
    logic [65:0] e;
    int unsigned sent = 0, rcvd = 0, cyc = 0;
    while (rcvd < 200 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      in_valid_64 = (sent < 200) && ($urandom_range(3) != 0);
      case (sent % 4)
        0:       begin a_64 = '1; b_64 = 64'(1'($urandom)); end
        1:       begin a_64 = 64'h7FFF_FFFF_FFFF_FFFF; b_64 = {$urandom, $urandom}; end
        default: begin a_64 = {$urandom, $urandom}; b_64 = {$urandom, $urandom}; end
      endcase
      cin_64 = 1'($urandom);
      out_ready_64 = ($urandom_range(2) != 0);
      #1;
      if (out_valid_64 && out_ready_64) begin
        e = q.pop_front();
        rcvd++;
        n_tests++;
        if (sum_64 !== e[63:0] || cout_64 !== e[64]) begin
          n_fail++;
          $display("FAIL w64_data #%0d got sum=%h cout=%b exp sum=%h cout=%b", rcvd, sum_64, cout_64, e[63:0], e[64]);
        end
`ifdef CLA_OVF_FLAG_EN
        n_tests++;
        if (ovf_64 !== e[65]) begin
          n_fail++;
          $display("FAIL w64_ovf #%0d got %b exp %b", rcvd, ovf_64, e[65]);
        end
`endif
      end
      if (in_valid_64 && in_ready_64) begin
        q.push_back(ref_add(a_64, b_64, cin_64, 64));
        sent++;
      end
    end
    in_valid_64 = 1'b0;
    n_tests++;
    if (rcvd != 200) begin
      n_fail++;
      $display("FAIL w64_count got rcvd=%0d exp 200", rcvd);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_back_to_back();
    test_backpressure();
    test_random_toggle();
    test_reset_midstream();
    test_width4_exhaustive();
    test_width64();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
